// File: rtl/palette_pkg.sv
// Shared definitions for the palette fade controller.
// Register indices, STATUS bit positions, fade state type and a helper
// that maps a zero-valued field to 1.
package palette_pkg;

    localparam logic [1:0] REG_TARGET    = 2'd0;
    localparam logic [1:0] REG_CONFIG    = 2'd1;
    localparam logic [1:0] REG_STATUS    = 2'd2;
    localparam logic [1:0] REG_IMMEDIATE = 2'd3;

    // STATUS read bits
    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    // STATUS write bits
    localparam int CTRL_ABORT    = 0;
    localparam int CTRL_CLR_DONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } fade_state_e;

    // A zero step is meaningless; treat it as the smallest useful step.
    function automatic logic [7:0] eff8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/palette_fade_ctrl_frame_tick_div.sv
// Frame tick generator and frames-per-step divider.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   vblank        vblank level, synchronous to clk
//   enable        count ticks only while a fade is running
//   clear         restart the frame count (retarget)
//   div           raw frames-per-step field, 0 treated as 1
//   step_en       one-cycle strobe when a brightness step is due
module frame_tick_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vblank,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             step_en
);

    logic             vb_q, vb_qq;
    logic             tick;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_eff;
    logic             at_term;

    // vb_q is the sampled vblank, vb_qq its delayed copy; the tick is the
    // cycle right after vblank is first sampled high.
    assign tick    = vb_q & ~vb_qq;
    assign div_eff = (div == '0) ? DIV_W'(1) : div;
    // >= rather than == so that shrinking div mid-fade steps on the next tick.
    assign at_term = (cnt_q >= (div_eff - DIV_W'(1)));
    assign step_en = enable & tick & ~clear & at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && tick) begin
            cnt_d = at_term ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vb_q  <= 1'b0;
            vb_qq <= 1'b0;
            cnt_q <= '0;
        end else begin
            vb_q  <= vblank;
            vb_qq <= vb_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/palette_fade_ctrl.sv
// Memory-mapped brightness fade controller for the palette lookup.
// Ramps brightness toward a target by a step every N vblank frames.
// Ports:
//   clk, reset_n          clock and synchronous active-low reset
//   vblank                VGA vblank level
//   memenable/memaddr/memwrite/writedata   bus access
//   memdata               registered read data
//   brightness            to palette brightness input
//   busy, done_pulse      fade in progress / fade reached target
//
// state | meaning
// IDLE  | brightness static, no fade running
// FADE  | stepping brightness toward target on divided frame ticks
module palette_fade_ctrl
    import palette_pkg::*;
#(
    parameter int         DIV_W        = 8,
    parameter logic [7:0] RESET_BRIGHT = 8'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vblank,
    input  logic        memenable,
    input  logic [1:0]  memaddr,
    input  logic        memwrite,
    input  logic [15:0] writedata,
    output logic [15:0] memdata,
    output logic [7:0]  brightness,
    output logic        busy,
    output logic        done_pulse
);

    fade_state_e      state_q, state_d;
    logic [7:0]       bright_q, bright_d;
    logic [7:0]       target_q, target_d;
    logic [7:0]       step_q, step_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             done_sticky_q, done_sticky_d;
    logic             done_pulse_q, done_pulse_d;
    logic [15:0]      memdata_q, memdata_d;

    logic wr_en, rd_en;
    logic wr_target, wr_config, wr_status, wr_imm;
    logic step_en;
    logic [7:0]  step_eff, step_next;
    logic [8:0]  sum9, diff9;
    logic [15:0] rd_data;

    assign wr_en     = memenable & memwrite;
    assign rd_en     = memenable & ~memwrite;
    assign wr_target = wr_en && (memaddr == REG_TARGET);
    assign wr_config = wr_en && (memaddr == REG_CONFIG);
    assign wr_status = wr_en && (memaddr == REG_STATUS);
    assign wr_imm    = wr_en && (memaddr == REG_IMMEDIATE);

    frame_tick_div #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .vblank  (vblank),
        .enable  (state_q == FADE),
        .clear   (wr_target),
        .div     (div_q),
        .step_en (step_en)
    );

    // 9-bit arithmetic so overflow above 255 and underflow below 0 both
    // clamp to the target instead of wrapping.
    assign step_eff = eff8(step_q);
    assign sum9     = {1'b0, bright_q} + {1'b0, step_eff};
    assign diff9    = {1'b0, bright_q} - {1'b0, step_eff};

    always_comb begin
        if (target_q > bright_q) begin
            step_next = (sum9 >= {1'b0, target_q}) ? target_q : sum9[7:0];
        end else begin
            step_next = (diff9[8] || (diff9[7:0] <= target_q)) ? target_q : diff9[7:0];
        end
    end

    always_comb begin
        rd_data = '0;
        case (memaddr)
            REG_TARGET: rd_data[7:0] = bright_q;
            REG_CONFIG: begin
                rd_data[7:0]       = step_q;
                rd_data[8 +: DIV_W] = div_q;
            end
            REG_STATUS: begin
                rd_data[STAT_BUSY] = (state_q == FADE);
                rd_data[STAT_DONE] = done_sticky_q;
            end
            default:    rd_data[7:0] = target_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bright_d      = bright_q;
        target_d      = target_q;
        step_d        = step_q;
        div_d         = div_q;
        done_sticky_d = done_sticky_q;
        done_pulse_d  = 1'b0;
        memdata_d     = rd_en ? rd_data : memdata_q;

        if (wr_config) begin
            step_d = writedata[7:0];
            div_d  = writedata[8 +: DIV_W];
        end
        if (wr_status && writedata[CTRL_CLR_DONE]) begin
            done_sticky_d = 1'b0;
        end

        if (wr_imm) begin
            bright_d = writedata[7:0];
            target_d = writedata[7:0];
            state_d  = IDLE;
        end else if (wr_status && writedata[CTRL_ABORT]) begin
            state_d = IDLE;
        end else if (wr_target) begin
            target_d = writedata[7:0];
            if (writedata[7:0] == bright_q) begin
                state_d       = IDLE;
                done_sticky_d = 1'b1;
                done_pulse_d  = 1'b1;
            end else begin
                state_d       = FADE;
                done_sticky_d = 1'b0;
            end
        end else if ((state_q == FADE) && step_en) begin
            bright_d = step_next;
            if (step_next == target_q) begin
                state_d       = IDLE;
                done_sticky_d = 1'b1;
                done_pulse_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bright_q      <= RESET_BRIGHT;
            target_q      <= RESET_BRIGHT;
            step_q        <= 8'd1;
            div_q         <= DIV_W'(1);
            done_sticky_q <= 1'b0;
            done_pulse_q  <= 1'b0;
            memdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            bright_q      <= bright_d;
            target_q      <= target_d;
            step_q        <= step_d;
            div_q         <= div_d;
            done_sticky_q <= done_sticky_d;
            done_pulse_q  <= done_pulse_d;
            memdata_q     <= memdata_d;
        end
    end

    assign memdata    = memdata_q;
    assign brightness = bright_q;
    assign busy       = (state_q == FADE);
    assign done_pulse = done_pulse_q;

endmodule
